// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
// Takes the EX/MEM load/store controls, issues one valid/ready request on the
// data-memory bus per access, formats load data for MEM/WB and holds the
// front of the pipeline via stall_out until the access has finished.
module mem_stage_lsu #(
   parameter int DATA_W = 64,
   parameter int STRB_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead_in,
   input  logic              memWrite_in,
   input  logic [2:0]        memType_in,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] writeData_in,
   output logic              stall_out,
   output logic [DATA_W-1:0] loadData_out,
   output logic              loadValid_out,
   output logic              misaligned_out,
   output logic              accessFault_out,
   output logic [DATA_W-1:0] faultAddr_out,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [STRB_W-1:0] dmem_wstrb,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   // Everything the bus request needs, frozen at acceptance so the bus sees
   // stable fields however long req_ready stays low.
   typedef struct packed {
      logic              we;
      logic [2:0]        mtype;
      logic [2:0]        off;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   state_t            state_q, state_d;
   req_t              req_q;
   logic              mis_q, err_q, rd_ok_q;

   logic              start;
   logic              fault_in;
   logic [STRB_W-1:0] size_mask;
   logic [5:0]        shamt_in;
   logic [DATA_W-1:0] wdata_fmt;
   logic [STRB_W-1:0] wstrb_fmt;
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] rd_ext;

   // A simultaneous read and write is handled as a write.
   assign start = memRead_in | memWrite_in;

   // Alignment check on the incoming access; reserved type always faults.
   always_comb begin
      fault_in = 1'b0;
      case (memType_in)
         3'b001, 3'b101: fault_in = addr_in[0];
         3'b010, 3'b110: fault_in = |addr_in[1:0];
         3'b011:         fault_in = |addr_in[2:0];
         3'b111:         fault_in = 1'b1;
         default:        fault_in = 1'b0;
      endcase
   end

   // Byte-enable mask for the access size before lane shifting.
   always_comb begin
      size_mask = '0;
      case (memType_in[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Move LSB-aligned store data and strobes onto the addressed byte lanes.
   assign shamt_in  = {addr_in[2:0], 3'b000};
   assign wdata_fmt = writeData_in << shamt_in;
   assign wstrb_fmt = size_mask << addr_in[2:0];

   // Bring the addressed lane of read data down to bit 0.
   assign rd_shift = dmem_rdata >> {req_q.off, 3'b000};

   // Sign/zero extension of the load result according to the latched type.
   always_comb begin
      rd_ext = rd_shift;
      case (req_q.mtype)
         3'b000:  rd_ext = {{(DATA_W-8){rd_shift[7]}},   rd_shift[7:0]};
         3'b001:  rd_ext = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  rd_ext = {{(DATA_W-32){rd_shift[31]}}, rd_shift[31:0]};
         3'b100:  rd_ext = {{(DATA_W-8){1'b0}},          rd_shift[7:0]};
         3'b101:  rd_ext = {{(DATA_W-16){1'b0}},         rd_shift[15:0]};
         3'b110:  rd_ext = {{(DATA_W-32){1'b0}},         rd_shift[31:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   // State register; reset drops req_valid at once and forgets the access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state plus the state-decoded handshake, stall and pulse outputs.
   always_comb begin
      state_d         = state_q;
      stall_out       = 1'b0;
      dmem_req_valid  = 1'b0;
      loadValid_out   = 1'b0;
      misaligned_out  = 1'b0;
      accessFault_out = 1'b0;
      case (state_q)
         IDLE: begin
            stall_out = start;
            if (start) state_d = fault_in ? DONE : REQ;
         end
         REQ: begin
            stall_out      = 1'b1;
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            stall_out = 1'b1;
            if (dmem_rvalid) state_d = DONE;
         end
         DONE: begin
            // Stall is low here so the pipeline moves on; inputs are not
            // looked at, which keeps the same instruction from reissuing.
            loadValid_out   = rd_ok_q;
            misaligned_out  = mis_q;
            accessFault_out = err_q;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the request on acceptance and capture the response in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q         <= '0;
         mis_q         <= 1'b0;
         err_q         <= 1'b0;
         rd_ok_q       <= 1'b0;
         loadData_out  <= '0;
         faultAddr_out <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mis_q   <= fault_in;
                  err_q   <= 1'b0;
                  rd_ok_q <= 1'b0;
                  if (fault_in) begin
                     faultAddr_out <= addr_in;
                  end else begin
                     req_q.we    <= memWrite_in;
                     req_q.mtype <= memType_in;
                     req_q.off   <= addr_in[2:0];
                     req_q.addr  <= addr_in;
                     req_q.wdata <= memWrite_in ? wdata_fmt : '0;
                     req_q.wstrb <= memWrite_in ? wstrb_fmt : '0;
                  end
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  if (dmem_err) begin
                     err_q         <= 1'b1;
                     faultAddr_out <= req_q.addr;
                  end else if (!req_q.we) begin
                     loadData_out <= rd_ext;
                     rd_ok_q      <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bus fields come straight from the frozen request.
   assign dmem_we    = req_q.we;
   assign dmem_addr  = {req_q.addr[DATA_W-1:3], 3'b000};
   assign dmem_wdata = req_q.wdata;
   assign dmem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table of accesses with hand-derived expectations pushed
// to a scoreboard queue when driven and popped when the DONE cycle arrives,
// plus hand-written reset sequences.
module tb_mem_stage_lsu;

   localparam int K_LOAD  = 0;
   localparam int K_STORE = 1;
   localparam int K_MIS   = 2;
   localparam int K_ERR   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead_in, memWrite_in;
   logic [2:0]  memType_in;
   logic [63:0] addr_in, writeData_in;
   logic        stall_out;
   logic [63:0] loadData_out;
   logic        loadValid_out, misaligned_out, accessFault_out;
   logic [63:0] faultAddr_out;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic        dmem_err;

   always #5 clk = ~clk;

   mem_stage_lsu #(.DATA_W(64), .STRB_W(8)) dut (
      .clk(clk), .reset(reset),
      .memRead_in(memRead_in), .memWrite_in(memWrite_in), .memType_in(memType_in),
      .addr_in(addr_in), .writeData_in(writeData_in),
      .stall_out(stall_out), .loadData_out(loadData_out), .loadValid_out(loadValid_out),
      .misaligned_out(misaligned_out), .accessFault_out(accessFault_out),
      .faultAddr_out(faultAddr_out),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
   );

   typedef struct {
      logic        rd, wr;
      logic [2:0]  mt;
      logic [63:0] addr, wdata, rdata;
      logic        err;
      int          dly;
      logic        exp_req, exp_we;
      logic [63:0] exp_daddr, exp_wdata;
      logic [7:0]  exp_wstrb;
      int          exp_kind;
      logic [63:0] exp_load, exp_faddr;
      int          exp_stall;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mt,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic err, input int dly,
                               input int kind, input logic [63:0] daddr,
                               input logic [63:0] ewdata, input logic [7:0] ewstrb,
                               input logic [63:0] eload, input logic [63:0] efaddr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.mt = mt; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.err = err; v.dly = dly; v.exp_kind = kind;
      v.exp_req   = (kind != K_MIS);
      v.exp_we    = wr;
      v.exp_daddr = daddr; v.exp_wdata = ewdata; v.exp_wstrb = ewstrb;
      v.exp_load  = eload; v.exp_faddr = efaddr;
      v.exp_stall = (kind == K_MIS) ? 1 : 3 + dly;
      return v;
   endfunction

   task automatic drop_inputs();
      memRead_in = 1'b0; memWrite_in = 1'b0; memType_in = 3'b000;
      addr_in = '0; writeData_in = '0;
   endtask

   // One access: drive, act as the bus, then pop and check at DONE.
   task automatic run_vec(input vec_t v, input string tag);
      vec_t e;
      bit   done = 1'b0;
      bit   hs = 1'b0;
      bit   req_seen = 1'b0;
      int   wait_cnt = 0;
      int   stall_cnt = 0;
      @(posedge clk); #1;
      memRead_in = v.rd; memWrite_in = v.wr; memType_in = v.mt;
      addr_in = v.addr; writeData_in = v.wdata;
      dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
      exp_q.push_back(v);
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         e = exp_q[0];
         if (stall_out) stall_cnt++;
         if (dmem_req_valid) begin
            req_seen = 1'b1;
            chk({tag, " dmem_addr"}, dmem_addr, e.exp_daddr);
            chk({tag, " dmem_we"}, {63'd0, dmem_we}, {63'd0, e.exp_we});
            chk({tag, " dmem_wstrb"}, {56'd0, dmem_wstrb}, {56'd0, e.exp_wstrb});
            if (e.exp_we) chk({tag, " dmem_wdata"}, dmem_wdata, e.exp_wdata);
         end
         dmem_rvalid = 1'b0; dmem_err = 1'b0;
         if (hs) begin
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata; dmem_err = v.err; hs = 1'b0;
         end
         if (dmem_req_valid) begin
            dmem_req_ready = (wait_cnt >= v.dly);
            hs = dmem_req_ready;
            wait_cnt++;
         end else begin
            dmem_req_ready = 1'b0;
         end
         if (!stall_out) begin
            done = 1'b1;
            e = exp_q.pop_front();
            chk({tag, " loadValid"}, {63'd0, loadValid_out}, {63'd0, e.exp_kind == K_LOAD});
            chk({tag, " misaligned"}, {63'd0, misaligned_out}, {63'd0, e.exp_kind == K_MIS});
            chk({tag, " accessFault"}, {63'd0, accessFault_out}, {63'd0, e.exp_kind == K_ERR});
            chk({tag, " loadData"}, loadData_out, e.exp_load);
            chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(e.exp_stall));
            chk({tag, " req_issued"}, {63'd0, req_seen}, {63'd0, e.exp_req});
            if (e.exp_kind == K_MIS || e.exp_kind == K_ERR)
               chk({tag, " faultAddr"}, faultAddr_out, e.exp_faddr);
            drop_inputs();
            dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_req_ready = 1'b0;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL %s timeout actual=no_done required=done", tag);
         void'(exp_q.pop_front());
         drop_inputs();
         dmem_rvalid = 1'b0; dmem_req_ready = 1'b0;
      end
      // Pulses are single-cycle and nothing restarts once inputs drop.
      @(negedge clk);
      chk({tag, " pulses_after"}, {61'd0, loadValid_out, misaligned_out, accessFault_out}, 64'd0);
      chk({tag, " stall_after"}, {63'd0, stall_out}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      drop_inputs();
      dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;

      //          rd wr  mt      addr          wdata                  rdata                 err dly kind     daddr         ewdata                 ewstrb  eload                   efaddr
      vecs.push_back(mk(1, 0, 3'b010, 64'h1004, 64'h0,                64'h80000000_11112222, 0, 0, K_LOAD,  64'h1000, 64'h0,                 8'h00, 64'hFFFFFFFF_80000000, 64'h0));
      vecs.push_back(mk(0, 1, 3'b001, 64'h2006, 64'hABCD,             64'h0,                 0, 0, K_STORE, 64'h2000, 64'hABCD0000_00000000, 8'hC0, 64'hFFFFFFFF_80000000, 64'h0));
      vecs.push_back(mk(1, 0, 3'b100, 64'h3003, 64'h0,                64'h00000000_F0000000, 0, 0, K_LOAD,  64'h3000, 64'h0,                 8'h00, 64'h00000000_000000F0, 64'h0));
      vecs.push_back(mk(1, 0, 3'b000, 64'h3003, 64'h0,                64'h00000000_F0000000, 0, 0, K_LOAD,  64'h3000, 64'h0,                 8'h00, 64'hFFFFFFFF_FFFFFFF0, 64'h0));
      vecs.push_back(mk(1, 0, 3'b011, 64'h4004, 64'h0,                64'h0,                 0, 0, K_MIS,   64'h0,    64'h0,                 8'h00, 64'hFFFFFFFF_FFFFFFF0, 64'h4004));
      vecs.push_back(mk(1, 0, 3'b001, 64'h5002, 64'h0,                64'h12345678_9ABCDEF0, 1, 5, K_ERR,   64'h5000, 64'h0,                 8'h00, 64'hFFFFFFFF_FFFFFFF0, 64'h5002));
      vecs.push_back(mk(1, 0, 3'b111, 64'h6000, 64'h0,                64'h0,                 0, 0, K_MIS,   64'h0,    64'h0,                 8'h00, 64'hFFFFFFFF_FFFFFFF0, 64'h6000));
      vecs.push_back(mk(0, 1, 3'b011, 64'h7000, 64'h11223344_55667788, 64'h0,                0, 0, K_STORE, 64'h7000, 64'h11223344_55667788, 8'hFF, 64'hFFFFFFFF_FFFFFFF0, 64'h0));
      vecs.push_back(mk(1, 0, 3'b110, 64'h8004, 64'h0,                64'h80000000_00000000, 0, 0, K_LOAD,  64'h8000, 64'h0,                 8'h00, 64'h00000000_80000000, 64'h0));
      vecs.push_back(mk(1, 0, 3'b101, 64'h8001, 64'h0,                64'h0,                 0, 0, K_MIS,   64'h0,    64'h0,                 8'h00, 64'h00000000_80000000, 64'h8001));
      vecs.push_back(mk(1, 1, 3'b010, 64'h9004, 64'hDEADBEEF,         64'hFFFFFFFF_FFFFFFFF, 0, 0, K_STORE, 64'h9000, 64'hDEADBEEF_00000000, 8'hF0, 64'h00000000_80000000, 64'h0));
      vecs.push_back(mk(1, 0, 3'b011, 64'hA000, 64'h0,                64'h01234567_89ABCDEF, 0, 2, K_LOAD,  64'hA000, 64'h0,                 8'h00, 64'h01234567_89ABCDEF, 64'h0));
      vecs.push_back(mk(0, 1, 3'b000, 64'hB005, 64'h1FF,              64'h0,                 0, 1, K_STORE, 64'hB000, 64'h0001FF00_00000000, 8'h20, 64'h01234567_89ABCDEF, 64'h0));
      vecs.push_back(mk(1, 0, 3'b001, 64'hC006, 64'h0,                64'h80010000_00000000, 0, 0, K_LOAD,  64'hC000, 64'h0,                 8'h00, 64'hFFFFFFFF_FFFF8001, 64'h0));
      vecs.push_back(mk(0, 1, 3'b010, 64'hD000, 64'h55,               64'h0,                 1, 0, K_ERR,   64'hD000, 64'h00000000_00000055, 8'h0F, 64'hFFFFFFFF_FFFF8001, 64'hD000));

      // Reset state.
      #2;
      chk("rst stall", {63'd0, stall_out}, 64'd0);
      chk("rst req_valid", {63'd0, dmem_req_valid}, 64'd0);
      chk("rst pulses", {61'd0, loadValid_out, misaligned_out, accessFault_out}, 64'd0);
      chk("rst loadData", loadData_out, 64'd0);
      chk("rst faultAddr", faultAddr_out, 64'd0);
      chk("rst bus", {dmem_addr[55:0], dmem_wstrb} ^ {dmem_wdata[63:1], dmem_we}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset while waiting for the response; the late rvalid must be ignored.
      @(posedge clk); #1;
      memRead_in = 1'b1; memType_in = 3'b010; addr_in = 64'h1004;
      @(negedge clk);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      chk("rstw req_valid_in_req", {63'd0, dmem_req_valid}, 64'd1);
      @(negedge clk);
      chk("rstw stall_in_wait", {63'd0, stall_out}, 64'd1);
      reset = 1'b1;
      drop_inputs();
      dmem_req_ready = 1'b0;
      #1;
      chk("rstw stall", {63'd0, stall_out}, 64'd0);
      chk("rstw req_valid", {63'd0, dmem_req_valid}, 64'd0);
      chk("rstw loadData", loadData_out, 64'd0);
      chk("rstw faultAddr", faultAddr_out, 64'd0);
      chk("rstw dmem_addr", dmem_addr, 64'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 64'h80000000_11112222;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("rstw late_rvalid loadValid", {63'd0, loadValid_out}, 64'd0);
      chk("rstw late_rvalid loadData", loadData_out, 64'd0);
      chk("rstw late_rvalid stall", {63'd0, stall_out}, 64'd0);

      run_vec(vecs[0], "post_reset_lw");

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
